// File: rtl/psram_rcache_if.sv
`default_nettype none
// ============================================================================
//  Module      : psram_rcache_if
//  Description : Word-bus valid/ready handshake used on both sides of the
//                PSRAM read cache. The master drives the request (valid,
//                addr, wdata, wstrb) and the slave returns rdata together
//                with a one-cycle ready completion pulse. wstrb == 0 means a
//                read.
//  Signals     : valid, addr[31:0], wdata[31:0], wstrb[3:0]  (master -> slave)
//                rdata[31:0], ready                          (slave -> master)
//  Revision    : 1.0 - initial release
// ============================================================================
interface psram_rcache_if;
    logic        valid;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    logic        ready;

    modport master (
        output valid,
        output addr,
        output wdata,
        output wstrb,
        input  rdata,
        input  ready
    );

    modport slave (
        input  valid,
        input  addr,
        input  wdata,
        input  wstrb,
        output rdata,
        output ready
    );
endinterface
`default_nettype wire

// File: rtl/psram_rcache.sv
`default_nettype none
// ============================================================================
//  Module      : psram_rcache
//  Description : Direct-mapped, write-through, no-write-allocate one-word-line
//                cache between the core PSRAM bus and psram_top. Read hits
//                complete one cycle after the request; read misses fill the
//                line from PSRAM; every write is forwarded to PSRAM and merged
//                into the line only when that line already holds the word.
//  Ports       : clk_i      - clock, rising edge
//                rst_i      - synchronous active-high reset
//                flush_i    - one-cycle pulse invalidating every line
//                mem        - upstream slave port (core side)
//                psram      - downstream master port (psram_top side)
//                hit_cnt_o  - read-hit counter  (PSRAM_RCACHE_STAT_EN only)
//                miss_cnt_o - read-miss counter (PSRAM_RCACHE_STAT_EN only)
//  Options     : define PSRAM_RCACHE_STAT_EN to build the hit/miss counters
//  Revision    : 1.0 - initial release
// ============================================================================
module psram_rcache #(
    parameter int IDX_W = 6,
    parameter int TAG_W = 21 - IDX_W
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           flush_i,
    psram_rcache_if.slave  mem,
    psram_rcache_if.master psram
`ifdef PSRAM_RCACHE_STAT_EN
    ,
    output logic [31:0]    hit_cnt_o,
    output logic [31:0]    miss_cnt_o
`endif
);

    localparam int c_lines = 1 << IDX_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_WRITE = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t             r_state;
    logic [c_lines-1:0] r_valid;
    logic [TAG_W-1:0]   r_tag_mem  [c_lines];
    logic [31:0]        r_data_mem [c_lines];

    logic [31:0]        r_addr;
    logic [31:0]        r_wdata;
    logic [3:0]         r_wstrb;
    logic [31:0]        r_rdata;
    logic               r_ready;
    logic               r_psram_valid;
    logic               r_flush_pend;
`ifdef PSRAM_RCACHE_STAT_EN
    logic [31:0]        r_hit_cnt;
    logic [31:0]        r_miss_cnt;
`endif

    // Lookup of the live upstream request (used only in IDLE)
    logic [IDX_W-1:0]   w_idx;
    logic [TAG_W-1:0]   w_tag;
    logic               w_lookup_hit;
    // Lookup of the registered request (used in FILL / WRITE)
    logic [IDX_W-1:0]   w_r_idx;
    logic [TAG_W-1:0]   w_r_tag;
    logic               w_line_hit;
    logic               w_flush;
    logic               w_fill_we;
    logic               w_merge_we;
    logic [31:0]        w_merged;

    assign w_idx        = mem.addr[2+IDX_W-1:2];
    assign w_tag        = mem.addr[22:2+IDX_W];
    assign w_lookup_hit = r_valid[w_idx] && (r_tag_mem[w_idx] == w_tag);

    assign w_r_idx      = r_addr[2+IDX_W-1:2];
    assign w_r_tag      = r_addr[22:2+IDX_W];
    assign w_line_hit   = r_valid[w_r_idx] && (r_tag_mem[w_r_idx] == w_r_tag);

    // A flush seen outside IDLE is remembered and applied on the first IDLE
    // cycle, which is after any fill has written its line.
    assign w_flush      = flush_i | r_flush_pend;

    assign w_fill_we    = (r_state == S_FILL)  && psram.ready;
    assign w_merge_we   = (r_state == S_WRITE) && psram.ready && w_line_hit;

    always_comb begin
        w_merged = r_data_mem[w_r_idx];
        for (int b = 0; b < 4; b++) begin
            if (r_wstrb[b]) begin
                w_merged[8*b +: 8] = r_wdata[8*b +: 8];
            end
        end
    end

    // Tag/data storage needs no reset: the valid bits gate every use.
    always_ff @(posedge clk_i) begin
        if (w_fill_we) begin
            r_tag_mem[w_r_idx]  <= w_r_tag;
            r_data_mem[w_r_idx] <= psram.rdata;
        end else if (w_merge_we) begin
            r_data_mem[w_r_idx] <= w_merged;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state       <= S_IDLE;
            r_valid       <= '0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_wstrb       <= '0;
            r_rdata       <= '0;
            r_ready       <= 1'b0;
            r_psram_valid <= 1'b0;
            r_flush_pend  <= 1'b0;
`ifdef PSRAM_RCACHE_STAT_EN
            r_hit_cnt     <= '0;
            r_miss_cnt    <= '0;
`endif
        end else begin
            r_ready <= 1'b0;
            if (flush_i) begin
                r_flush_pend <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_flush) begin
                        // A request in the same cycle is held off and looked
                        // up against the emptied cache on the next cycle.
                        r_valid      <= '0;
                        r_flush_pend <= 1'b0;
                    end else if (mem.valid) begin
                        r_addr  <= {mem.addr[31:2], 2'b00};
                        r_wdata <= mem.wdata;
                        r_wstrb <= mem.wstrb;
                        if (mem.wstrb != 4'b0000) begin
                            r_psram_valid <= 1'b1;
                            r_state       <= S_WRITE;
                        end else if (w_lookup_hit) begin
                            r_rdata <= r_data_mem[w_idx];
                            r_ready <= 1'b1;
                            r_state <= S_RESP;
`ifdef PSRAM_RCACHE_STAT_EN
                            r_hit_cnt <= r_hit_cnt + 32'd1;
`endif
                        end else begin
                            r_psram_valid <= 1'b1;
                            r_state       <= S_FILL;
`ifdef PSRAM_RCACHE_STAT_EN
                            r_miss_cnt <= r_miss_cnt + 32'd1;
`endif
                        end
                    end
                end
                S_FILL: begin
                    if (psram.ready) begin
                        r_valid[w_r_idx] <= 1'b1;
                        r_rdata          <= psram.rdata;
                        r_psram_valid    <= 1'b0;
                        r_ready          <= 1'b1;
                        r_state          <= S_RESP;
                    end
                end
                S_WRITE: begin
                    if (psram.ready) begin
                        r_psram_valid <= 1'b0;
                        r_ready       <= 1'b1;
                        r_state       <= S_RESP;
                    end
                end
                S_RESP: begin
                    // Upstream valid is ignored here; the next request is
                    // taken no earlier than the following IDLE cycle.
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign mem.rdata   = r_rdata;
    assign mem.ready   = r_ready;
    assign psram.valid = r_psram_valid;
    assign psram.addr  = r_addr;
    assign psram.wdata = r_wdata;
    assign psram.wstrb = r_wstrb;

`ifdef PSRAM_RCACHE_STAT_EN
    assign hit_cnt_o  = r_hit_cnt;
    assign miss_cnt_o = r_miss_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_psram_rcache.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_psram_rcache
//  Description : Self-checking bench for psram_rcache. A behavioural PSRAM
//                with programmable latency backs the cache; expectations come
//                from the backing memory contents and a model of which word
//                each direct-mapped line currently holds.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_psram_rcache;
    localparam int IDX_W = 6;
    localparam int LINES = 1 << IDX_W;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    always #5 clk = ~clk;

    psram_rcache_if mem_bus();
    psram_rcache_if psram_bus();

`ifdef PSRAM_RCACHE_STAT_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    psram_rcache #(.IDX_W(IDX_W)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .flush_i    (flush),
        .mem        (mem_bus),
        .psram      (psram_bus)
`ifdef PSRAM_RCACHE_STAT_EN
        ,
        .hit_cnt_o  (hit_cnt),
        .miss_cnt_o (miss_cnt)
`endif
    );

    int nchk  = 0;
    int nfail = 0;

    // ---------------- behavioural PSRAM ----------------
    logic [31:0] pmem [int unsigned];
    int          lat = 1;
    int          cnt = 0;
    int          ds_reads = 0;
    int          ds_writes = 0;
    int          unstable = 0;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic [3:0]  cap_wstrb;

    function automatic logic [31:0] pm_rd(input int unsigned w);
        if (!pmem.exists(w)) pmem[w] = $urandom;
        return pmem[w];
    endfunction

    initial begin
        logic [31:0] v;
        int unsigned w;
        psram_bus.ready = 1'b0;
        psram_bus.rdata = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                psram_bus.ready = 1'b0;
                cnt = 0;
            end else if (psram_bus.ready) begin
                psram_bus.ready = 1'b0;
            end else if (!psram_bus.valid) begin
                cnt = 0;
            end else begin
                if (cnt == 0) begin
                    cap_addr  = psram_bus.addr;
                    cap_wdata = psram_bus.wdata;
                    cap_wstrb = psram_bus.wstrb;
                    if (cap_wstrb == 4'b0) ds_reads++;
                    else ds_writes++;
                end else if (psram_bus.addr !== cap_addr || psram_bus.wdata !== cap_wdata
                             || psram_bus.wstrb !== cap_wstrb) begin
                    unstable++;
                end
                cnt++;
                if (cnt >= lat) begin
                    w = 32'(cap_addr[22:2]);
                    v = pm_rd(w);
                    if (cap_wstrb == 4'b0) begin
                        psram_bus.rdata = v;
                    end else begin
                        for (int b = 0; b < 4; b++)
                            if (cap_wstrb[b]) v[8*b +: 8] = cap_wdata[8*b +: 8];
                        pmem[w] = v;
                        psram_bus.rdata = '0;
                    end
                    psram_bus.ready = 1'b1;
                    cnt = 0;
                end
            end
        end
    end

    // ---------------- cache residency model ----------------
    bit          mv    [LINES];
    logic [20:0] mword [LINES];
    int          exp_hit  = 0;
    int          exp_miss = 0;

    function automatic bit model_is_hit(input logic [31:0] a);
        int idx;
        idx = int'(a[22:2]) % LINES;
        return mv[idx] && (mword[idx] == a[22:2]);
    endfunction

    function automatic void model_read(input logic [31:0] a);
        int idx;
        idx = int'(a[22:2]) % LINES;
        if (model_is_hit(a)) begin
            exp_hit++;
        end else begin
            exp_miss++;
            mv[idx]    = 1'b1;
            mword[idx] = a[22:2];
        end
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < LINES; i++) mv[i] = 1'b0;
    endfunction

    // Issue one upstream request; reports data, cycles to ready, timeout and
    // whether ready was still high one cycle after the completion.
    task automatic do_req(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                          output logic [31:0] rd, output int cyc, output bit tmo,
                          output bit extra_rdy);
        @(negedge clk);
        mem_bus.valid = 1'b1;
        mem_bus.addr  = a;
        mem_bus.wdata = wd;
        mem_bus.wstrb = ws;
        cyc = 0;
        tmo = 1'b1;
        rd  = '0;
        while (cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
            if (mem_bus.ready) begin
                tmo = 1'b0;
                rd  = mem_bus.rdata;
                break;
            end
        end
        mem_bus.valid = 1'b0;
        @(posedge clk);
        #1;
        extra_rdy = mem_bus.ready;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        nchk++; if (mem_bus.ready !== 1'b0) begin nfail++; $display("FAIL reset_ready got=%0b exp=0", mem_bus.ready); end
        nchk++; if (mem_bus.rdata !== 32'h0) begin nfail++; $display("FAIL reset_rdata got=%h exp=0", mem_bus.rdata); end
        nchk++; if (psram_bus.valid !== 1'b0) begin nfail++; $display("FAIL reset_pvalid got=%0b exp=0", psram_bus.valid); end
        nchk++; if ({psram_bus.addr, psram_bus.wdata, psram_bus.wstrb} !== 68'h0) begin
            nfail++; $display("FAIL reset_pbus got=%h/%h/%h exp=0", psram_bus.addr, psram_bus.wdata, psram_bus.wstrb); end
`ifdef PSRAM_RCACHE_STAT_EN
        nchk++; if (hit_cnt !== 0 || miss_cnt !== 0) begin nfail++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", hit_cnt, miss_cnt); end
`endif
    endtask

    task automatic test_fill_hit();
        logic [31:0] rd; int cyc; bit tmo, xr; int r0;
        pmem[32'h4] = 32'hDEADBEEF;
        lat = 1;
        r0 = ds_reads;
        do_req(32'h10, 32'h0, 4'h0, rd, cyc, tmo, xr);
        model_read(32'h10);
        nchk++; if (tmo || rd !== 32'hDEADBEEF) begin nfail++; $display("FAIL fill_data got=%h tmo=%0b exp=deadbeef", rd, tmo); end
        nchk++; if (ds_reads - r0 !== 1) begin nfail++; $display("FAIL fill_dsreads got=%0d exp=1", ds_reads - r0); end
        nchk++; if (cyc !== lat + 1) begin nfail++; $display("FAIL fill_latency got=%0d exp=%0d", cyc, lat + 1); end
        nchk++; if (xr !== 1'b0) begin nfail++; $display("FAIL fill_ready_pulse got=%0b exp=0", xr); end
        nchk++; if (cap_addr !== 32'h10 || cap_wstrb !== 4'h0) begin nfail++; $display("FAIL fill_paddr got=%h/%h exp=10/0", cap_addr, cap_wstrb); end
        r0 = ds_reads;
        do_req(32'h10, 32'h0, 4'h0, rd, cyc, tmo, xr);
        model_read(32'h10);
        nchk++; if (rd !== 32'hDEADBEEF) begin nfail++; $display("FAIL hit_data got=%h exp=deadbeef", rd); end
        nchk++; if (cyc !== 1) begin nfail++; $display("FAIL hit_latency got=%0d exp=1", cyc); end
        nchk++; if (ds_reads !== r0) begin nfail++; $display("FAIL hit_dsreads got=%0d exp=0", ds_reads - r0); end
`ifdef PSRAM_RCACHE_STAT_EN
        nchk++; if (hit_cnt !== 1 || miss_cnt !== 1) begin nfail++; $display("FAIL hit_cnt got=%0d/%0d exp=1/1", hit_cnt, miss_cnt); end
`endif
    endtask

    task automatic test_conflict();
        logic [31:0] rd; int cyc; bit tmo, xr; int r0;
        pmem[32'h44] = 32'h11001100;
        r0 = ds_reads;
        do_req(32'h110, 32'h0, 4'h0, rd, cyc, tmo, xr);
        model_read(32'h110);
        nchk++; if (rd !== 32'h11001100) begin nfail++; $display("FAIL conflict_data got=%h exp=11001100", rd); end
        do_req(32'h10, 32'h0, 4'h0, rd, cyc, tmo, xr);
        model_read(32'h10);
        nchk++; if (rd !== 32'hDEADBEEF) begin nfail++; $display("FAIL conflict_reread got=%h exp=deadbeef", rd); end
        nchk++; if (ds_reads - r0 !== 2) begin nfail++; $display("FAIL conflict_dsreads got=%0d exp=2", ds_reads - r0); end
`ifdef PSRAM_RCACHE_STAT_EN
        nchk++; if (miss_cnt !== 3) begin nfail++; $display("FAIL conflict_miss_cnt got=%0d exp=3", miss_cnt); end
`endif
    endtask

    task automatic test_write_hit();
        logic [31:0] rd; int cyc; bit tmo, xr; int w0, r0;
        w0 = ds_writes;
        do_req(32'h10, 32'h00001234, 4'b0011, rd, cyc, tmo, xr);
        nchk++; if (ds_writes - w0 !== 1) begin nfail++; $display("FAIL wrhit_dswrites got=%0d exp=1", ds_writes - w0); end
        nchk++; if (cap_addr !== 32'h10 || cap_wdata !== 32'h1234 || cap_wstrb !== 4'b0011) begin
            nfail++; $display("FAIL wrhit_pbus got=%h/%h/%h exp=10/1234/3", cap_addr, cap_wdata, cap_wstrb); end
        nchk++; if (cyc !== lat + 1) begin nfail++; $display("FAIL wrhit_latency got=%0d exp=%0d", cyc, lat + 1); end
        r0 = ds_reads;
        do_req(32'h10, 32'h0, 4'h0, rd, cyc, tmo, xr);
        model_read(32'h10);
        nchk++; if (rd !== 32'hDEAD1234 || cyc !== 1 || ds_reads !== r0) begin
            nfail++; $display("FAIL wrhit_read got=%h cyc=%0d ds=%0d exp=dead1234 cyc=1 ds=0", rd, cyc, ds_reads - r0); end
    endtask

    task automatic test_write_miss();
        logic [31:0] rd; int cyc; bit tmo, xr; int w0, r0;
        w0 = ds_writes;
        do_req(32'h200, 32'hA5A5A5A5, 4'b1111, rd, cyc, tmo, xr);
        nchk++; if (ds_writes - w0 !== 1 || cap_addr !== 32'h200) begin
            nfail++; $display("FAIL wrmiss_ds got=%0d addr=%h exp=1 addr=200", ds_writes - w0, cap_addr); end
        r0 = ds_reads;
        do_req(32'h200, 32'h0, 4'h0, rd, cyc, tmo, xr);
        model_read(32'h200);
        nchk++; if (ds_reads - r0 !== 1 || rd !== 32'hA5A5A5A5) begin
            nfail++; $display("FAIL wrmiss_read got=%h ds=%0d exp=a5a5a5a5 ds=1", rd, ds_reads - r0); end
    endtask

    task automatic test_flush_fill();
        logic [31:0] rd; int cyc; bit tmo, xr; int r0;
        pmem[32'hC] = 32'h3C3C3C3C;
        lat = 5;
        r0 = ds_reads;
        fork
            do_req(32'h30, 32'h0, 4'h0, rd, cyc, tmo, xr);
            begin
                repeat (2) @(negedge clk);
                flush = 1'b1;
                @(negedge clk);
                flush = 1'b0;
            end
        join
        model_read(32'h30);
        model_clear();
        nchk++; if (tmo || rd !== 32'h3C3C3C3C || cyc !== 6) begin
            nfail++; $display("FAIL flushfill_data got=%h cyc=%0d exp=3c3c3c3c cyc=6", rd, cyc); end
        do_req(32'h30, 32'h0, 4'h0, rd, cyc, tmo, xr);
        model_read(32'h30);
        nchk++; if (ds_reads - r0 !== 2 || rd !== 32'h3C3C3C3C) begin
            nfail++; $display("FAIL flushfill_remiss got=%h ds=%0d exp=3c3c3c3c ds=2", rd, ds_reads - r0); end
        r0 = ds_reads;
        do_req(32'h10, 32'h0, 4'h0, rd, cyc, tmo, xr);
        model_read(32'h10);
        nchk++; if (ds_reads - r0 !== 1 || rd !== 32'hDEAD1234) begin
            nfail++; $display("FAIL flushfill_other got=%h ds=%0d exp=dead1234 ds=1", rd, ds_reads - r0); end
    endtask

    task automatic test_flush_idle();
        logic [31:0] rd; int cyc; bit tmo, xr; int r0;
        lat = 2;
        r0 = ds_reads;
        fork
            do_req(32'h30, 32'h0, 4'h0, rd, cyc, tmo, xr);
            begin
                @(negedge clk);
                flush = 1'b1;
                @(negedge clk);
                flush = 1'b0;
            end
        join
        model_clear();
        model_read(32'h30);
        nchk++; if (cyc !== lat + 2 || ds_reads - r0 !== 1 || rd !== 32'h3C3C3C3C) begin
            nfail++; $display("FAIL flushidle got cyc=%0d ds=%0d rd=%h exp cyc=%0d ds=1 rd=3c3c3c3c", cyc, ds_reads - r0, rd, lat + 2); end
    endtask

    task automatic test_back_to_back();
        logic r1, r2, r3; int r0;
        r0 = ds_reads;
        @(negedge clk);
        mem_bus.valid = 1'b1;
        mem_bus.addr  = 32'h30;
        mem_bus.wstrb = 4'h0;
        @(posedge clk); #1; r1 = mem_bus.ready;
        @(posedge clk); #1; r2 = mem_bus.ready;
        @(posedge clk); #1; r3 = mem_bus.ready;
        mem_bus.valid = 1'b0;
        @(posedge clk); #1;
        model_read(32'h30);
        model_read(32'h30);
        nchk++; if ({r1, r2, r3} !== 3'b101) begin nfail++; $display("FAIL b2b_ready got=%b exp=101", {r1, r2, r3}); end
        nchk++; if (ds_reads !== r0 || mem_bus.rdata !== 32'h3C3C3C3C) begin
            nfail++; $display("FAIL b2b_hits got ds=%0d rd=%h exp ds=0 rd=3c3c3c3c", ds_reads - r0, mem_bus.rdata); end
    endtask

    task automatic test_random();
        logic [31:0] rd, a, wd; logic [3:0] ws; int cyc; bit tmo, xr, hit;
        int r0, w0; int unsigned w;
        for (int it = 0; it < 80; it++) begin
            lat = $urandom_range(1, 4);
            if ($urandom_range(0, 9) == 0) begin
                @(negedge clk); flush = 1'b1;
                @(negedge clk); flush = 1'b0;
                model_clear();
            end
            w = $urandom_range(0, 3) + LINES * $urandom_range(0, 2);
            a = w << 2;
            r0 = ds_reads;
            w0 = ds_writes;
            if ($urandom_range(0, 9) < 3) begin
                wd = $urandom;
                ws = 4'($urandom_range(1, 15));
                do_req(a, wd, ws, rd, cyc, tmo, xr);
                nchk++; if (tmo || cyc !== lat + 1 || ds_writes - w0 !== 1 || cap_addr !== a
                            || cap_wdata !== wd || cap_wstrb !== ws || xr !== 1'b0) begin
                    nfail++; $display("FAIL rand_write it=%0d cyc=%0d ds=%0d addr=%h strb=%h exp cyc=%0d addr=%h strb=%h",
                                      it, cyc, ds_writes - w0, cap_addr, cap_wstrb, lat + 1, a, ws); end
            end else begin
                hit = model_is_hit(a);
                do_req(a, 32'h0, 4'h0, rd, cyc, tmo, xr);
                model_read(a);
                nchk++; if (tmo || rd !== pm_rd(w) || cyc !== (hit ? 1 : lat + 1)
                            || ds_reads - r0 !== (hit ? 0 : 1) || xr !== 1'b0) begin
                    nfail++; $display("FAIL rand_read it=%0d addr=%h got rd=%h cyc=%0d ds=%0d exp rd=%h cyc=%0d ds=%0d",
                                      it, a, rd, cyc, ds_reads - r0, pm_rd(w), hit ? 1 : lat + 1, hit ? 0 : 1); end
            end
        end
        nchk++; if (unstable !== 0) begin nfail++; $display("FAIL psram_bus_stable got=%0d exp=0", unstable); end
`ifdef PSRAM_RCACHE_STAT_EN
        nchk++; if (hit_cnt !== 32'(exp_hit) || miss_cnt !== 32'(exp_miss) ) begin
            nfail++; $display("FAIL rand_cnt got=%0d/%0d exp=%0d/%0d", hit_cnt, miss_cnt, exp_hit, exp_miss); end
`endif
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; int cyc; bit tmo, xr; int r0;
        lat = 1;
        do_req(32'h10, 32'h0, 4'h0, rd, cyc, tmo, xr);
        model_read(32'h10);
        lat = 8;
        @(negedge clk);
        mem_bus.valid = 1'b1;
        mem_bus.addr  = 32'h40;
        mem_bus.wstrb = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        nchk++; if (psram_bus.valid !== 1'b1) begin nfail++; $display("FAIL rstmid_pending got=%0b exp=1", psram_bus.valid); end
        @(negedge clk);
        rst = 1'b1;
        mem_bus.valid = 1'b0;
        @(posedge clk); #1;
        nchk++; if (psram_bus.valid !== 1'b0 || mem_bus.ready !== 1'b0) begin
            nfail++; $display("FAIL rstmid_abort got pvalid=%0b ready=%0b exp=0/0", psram_bus.valid, mem_bus.ready); end
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        exp_hit  = 0;
        exp_miss = 0;
`ifdef PSRAM_RCACHE_STAT_EN
        nchk++; if (hit_cnt !== 0 || miss_cnt !== 0) begin nfail++; $display("FAIL rstmid_cnt got=%0d/%0d exp=0/0", hit_cnt, miss_cnt); end
`endif
        lat = 2;
        r0 = ds_reads;
        do_req(32'h10, 32'h0, 4'h0, rd, cyc, tmo, xr);
        model_read(32'h10);
        nchk++; if (tmo || cyc !== lat + 1 || ds_reads - r0 !== 1 || rd !== pm_rd(4)) begin
            nfail++; $display("FAIL rstmid_miss got cyc=%0d ds=%0d rd=%h exp cyc=%0d ds=1 rd=%h", cyc, ds_reads - r0, rd, lat + 1, pm_rd(4)); end
`ifdef PSRAM_RCACHE_STAT_EN
        nchk++; if (hit_cnt !== 0 || miss_cnt !== 1) begin nfail++; $display("FAIL rstmid_cnt2 got=%0d/%0d exp=0/1", hit_cnt, miss_cnt); end
`endif
    endtask

    initial begin
        rst           = 1'b1;
        flush         = 1'b0;
        mem_bus.valid = 1'b0;
        mem_bus.addr  = '0;
        mem_bus.wdata = '0;
        mem_bus.wstrb = '0;
        test_reset();
        test_fill_hit();
        test_conflict();
        test_write_hit();
        test_write_miss();
        test_flush_fill();
        test_flush_idle();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #500000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
